noc_phase_sequencer: RTL and testbench
======================================

NOC_PHASE_SEQUENCER -- requirements
Module: noc_phase_sequencer

Interface
REQ-001 Parameter MAX_ROUTER, default 16, sets the number of routers sequenced.
REQ-002 Parameter IN_CYCLE_SIZE, default 16, sets the width of the simulation-cycle counter.
REQ-003 Parameter OP_SIZE, default 2, sets the width of the broadcast op code.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- halt  in  1  level request to stop at the next cycle boundary.
- cfg_max_cycles  in  IN_CYCLE_SIZE  number of NoC cycles per run.
- router_en  in  MAX_ROUTER  mask of populated routers.
- done  in  MAX_ROUTER  per-router phase-complete flags.
- op  out  OP_SIZE  op broadcast to all routers.
- in_cycle  out  IN_CYCLE_SIZE  current NoC cycle number.
- busy  out  1  high while a run is active.
- finished  out  1  one-cycle pulse at run end.
- error  out  1  sticky watchdog error flag.

Function
REQ-006 Op encoding SHALL be: NOP=0, LOAD_STAGING=1, PHASE0=2, PHASE1=3.
REQ-007 FSM states SHALL be IDLE, LOAD, PH0, PH1, FIN and ERR; op SHALL be registered as NOP, LOAD_STAGING, PHASE0, PHASE1, NOP and NOP respectively, valid on the cycle of state entry.
REQ-008 all_done SHALL equal the AND over i of (done[i] | ~router_en[i]); router_en all-zero gives all_done=1.
REQ-009 IDLE: start with cfg_max_cycles!=0 -> LOAD, in_cycle<=0, busy<=1; start with cfg_max_cycles==0 -> FIN (no op issued); start while not IDLE SHALL be ignored.
REQ-010 LOAD -> PH0 and PH0 -> PH1 SHALL occur on the first clk edge where the state has been held at least one cycle and all_done=1; otherwise the state SHALL hold.
REQ-011 PH1 exit on all_done: in_cycle<=in_cycle+1; if in_cycle+1==cfg_max_cycles or halt=1 -> FIN, else -> LOAD.
REQ-012 Minimum per-NoC-cycle latency SHALL be 3 clks (LOAD, PH0, PH1 one clk each when all_done is already high).
REQ-013 FIN SHALL assert finished for exactly one cycle, clear busy, and go to IDLE next cycle; in_cycle SHALL hold its final value until the next start.
REQ-014 halt asserted in LOAD or PH0 SHALL take effect only at PH1 exit; a NoC cycle is never truncated.
REQ-015 cfg_max_cycles and router_en SHALL be sampled continuously; software changes them only in IDLE (change mid-run is unsupported but must not deadlock beyond watchdog behaviour).
REQ-016 in_cycle SHALL never wrap within a run, because the run stops at cfg_max_cycles <= 2^IN_CYCLE_SIZE-1.

Reset
REQ-017 rst_n low SHALL immediately force state=IDLE, op=NOP, in_cycle=0, busy=0, finished=0, error=0, watchdog=0, including mid-run.
REQ-018 The first state change after reset release SHALL require a start pulse.

Configuration
REQ-019 Macro SEQ_WATCHDOG_EN: when defined, a 16-bit watchdog SHALL count clks spent in any of LOAD, PH0 or PH1 with all_done=0, clearing on every state change.
REQ-020 When the watchdog reaches parameter WD_LIMIT (default 1024), the FSM SHALL go to ERR, set error=1 and busy=0; ERR exits to IDLE only on start, which clears error.
REQ-021 When SEQ_WATCHDOG_EN is undefined, there SHALL be no watchdog logic, ERR is unreachable, error is tied 0, and the FSM waits indefinitely for all_done.

Verification
REQ-022 Reset, router_en=all ones, done=all ones, start with cfg_max_cycles=2 -> op sequence 1,2,3,1,2,3 on consecutive clks; in_cycle ends at 2; finished pulses once; busy high for 7 clks.
REQ-023 done[5]=0 held for 4 clks during PH0 with router_en[5]=1 -> op stays 2 for 5 clks; repeat with router_en[5]=0 -> no stall.
REQ-024 halt=1 raised in LOAD of cycle 0, cfg_max_cycles=10 -> run completes PH1, in_cycle=1, finished pulses, state returns to IDLE.
REQ-025 start with cfg_max_cycles=0 -> no non-NOP op issued, finished pulses one clk later, in_cycle=0.
REQ-026 rst_n asserted asynchronously mid-PH0 -> op=0, busy=0 and in_cycle=0 immediately without waiting for a clk edge; with SEQ_WATCHDOG_EN defined, done stuck at 0 -> error=1 after 1024 clks, and the next start clears error.

Source files
------------

// File: rtl/noc_phase_sequencer.sv
// Broadcasts LOAD_STAGING / PHASE0 / PHASE1 ops to a set of NoC routers and waits for all of them to finish each phase.
// Define SEQ_WATCHDOG_EN to add a stall watchdog that moves the sequencer to an error state.
module noc_phase_sequencer #(
  parameter int MAX_ROUTER    = 16,
  parameter int IN_CYCLE_SIZE = 16,
  parameter int OP_SIZE       = 2
`ifdef SEQ_WATCHDOG_EN
  , parameter int WD_LIMIT    = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     halt,
  input  logic [IN_CYCLE_SIZE-1:0] cfg_max_cycles,
  input  logic [MAX_ROUTER-1:0]    router_en,
  input  logic [MAX_ROUTER-1:0]    done,
  output logic [OP_SIZE-1:0]       op,
  output logic [IN_CYCLE_SIZE-1:0] in_cycle,
  output logic                     busy,
  output logic                     finished,
  output logic                     error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PH0  = 3'd2,
    PH1  = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [OP_SIZE-1:0]       OP_NOP    = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0]       OP_LOAD   = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0]       OP_PHASE0 = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0]       OP_PHASE1 = OP_SIZE'(3);
  localparam logic [IN_CYCLE_SIZE-1:0] CYCLE_ONE = IN_CYCLE_SIZE'(1);

  state_t                     state, state_nx;
  logic [OP_SIZE-1:0]         op_nx;
  logic [IN_CYCLE_SIZE-1:0]   cycle_nx;
  logic [IN_CYCLE_SIZE-1:0]   cycle_inc;
  logic                       busy_nx;
  logic                       finished_nx;
  logic                       all_done;
  logic                       active;

  // Routers that are not populated never hold up a phase.
  assign all_done  = &(done | ~router_en);
  assign active    = (state == LOAD) || (state == PH0) || (state == PH1);
  assign cycle_inc = in_cycle + CYCLE_ONE;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WD_LIMIT - 1);

  logic [15:0] wd_cnt, wd_nx;
  logic        error_q, error_nx;
  logic        wd_trip;

  assign wd_trip = active && !all_done && (wd_cnt == WD_LAST);
  assign error   = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cycle_nx = in_cycle;
    busy_nx  = busy;

    case (state)
      IDLE: begin
        if (start) begin
          cycle_nx = '0;
          if (cfg_max_cycles != '0) begin
            state_nx = LOAD;
            busy_nx  = 1'b1;
          end else begin
            state_nx = FIN;
          end
        end
      end
      LOAD: if (all_done) state_nx = PH0;
      PH0:  if (all_done) state_nx = PH1;
      PH1: begin
        // halt is only honoured here so a NoC cycle always runs to completion.
        if (all_done) begin
          cycle_nx = cycle_inc;
          if ((cycle_inc == cfg_max_cycles) || halt) state_nx = FIN;
          else                                        state_nx = LOAD;
        end
      end
      FIN: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      ERR: if (start) state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase

`ifdef SEQ_WATCHDOG_EN
    if (wd_trip) begin
      state_nx = ERR;
      busy_nx  = 1'b0;
    end
`endif

    case (state_nx)
      LOAD:    op_nx = OP_LOAD;
      PH0:     op_nx = OP_PHASE0;
      PH1:     op_nx = OP_PHASE1;
      default: op_nx = OP_NOP;
    endcase
    finished_nx = (state_nx == FIN);
  end

`ifdef SEQ_WATCHDOG_EN
  // The count restarts whenever the state moves, so it measures one continuous stall.
  always_comb begin
    wd_nx    = wd_cnt;
    error_nx = error_q;
    if (state_nx != state)          wd_nx = '0;
    else if (active && !all_done)   wd_nx = wd_cnt + 16'd1;
    if (state_nx == ERR)            error_nx = 1'b1;
    else if (state == ERR && start) error_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt  <= wd_nx;
      error_q <= error_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= OP_NOP;
      in_cycle <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_nx;
      op       <= op_nx;
      in_cycle <= cycle_nx;
      busy     <= busy_nx;
      finished <= finished_nx;
    end
  end

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// Directed self-checking bench for noc_phase_sequencer; samples outputs on the falling clock edge.
module tb_noc_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic [15:0] cfg_max_cycles;
  logic [15:0] router_en;
  logic [15:0] done;
  logic [1:0]  op;
  logic [15:0] in_cycle;
  logic        busy;
  logic        finished;
  logic        error;

  int checks;
  int errors;

  noc_phase_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .cfg_max_cycles (cfg_max_cycles),
    .router_en      (router_en),
    .done           (done),
    .op             (op),
    .in_cycle       (in_cycle),
    .busy           (busy),
    .finished       (finished),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Leaves the bench on the falling edge after the start pulse has been sampled.
  task automatic applyStimulus(input logic [15:0] cfg);
    @(negedge clk);
    cfg_max_cycles = cfg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int exp_ops[6];
    int busy_cnt;
    int fin_cnt;
    int wait_cnt;

    checks = 0;
    errors = 0;
    exp_ops = '{1, 2, 3, 1, 2, 3};
    rst_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    cfg_max_cycles = 16'd0;
    router_en = 16'hFFFF;
    done = 16'hFFFF;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_op", 32'(op), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_cycle", 32'(in_cycle), 32'd0);
    checkOutput("reset_finished", 32'(finished), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);

    // Two full NoC cycles with every router already done.
    applyStimulus(16'd2);
    busy_cnt = 0;
    fin_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("run2_op", 32'(op), 32'(exp_ops[i]));
      busy_cnt += int'(busy);
      fin_cnt += int'(finished);
      @(negedge clk);
    end
    checkOutput("run2_fin_op", 32'(op), 32'd0);
    checkOutput("run2_fin_in_cycle", 32'(in_cycle), 32'd2);
    for (int i = 0; i < 3; i++) begin
      busy_cnt += int'(busy);
      fin_cnt += int'(finished);
      @(negedge clk);
    end
    checkOutput("run2_busy_clks", 32'(busy_cnt), 32'd7);
    checkOutput("run2_finished_pulses", 32'(fin_cnt), 32'd1);
    checkOutput("run2_idle_in_cycle", 32'(in_cycle), 32'd2);

    // Router 5 holds PHASE0 for four extra clocks.
    applyStimulus(16'd1);
    checkOutput("stall_load_op", 32'(op), 32'd1);
    @(negedge clk);
    checkOutput("stall_ph0_op0", 32'(op), 32'd2);
    done[5] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("stall_ph0_hold", 32'(op), 32'd2);
    end
    done[5] = 1'b1;
    @(negedge clk);
    checkOutput("stall_ph1_op", 32'(op), 32'd3);
    @(negedge clk);
    checkOutput("stall_fin_pulse", 32'(finished), 32'd1);
    checkOutput("stall_fin_in_cycle", 32'(in_cycle), 32'd1);
    @(negedge clk);

    // Same stall on a depopulated router must be ignored.
    router_en[5] = 1'b0;
    applyStimulus(16'd1);
    @(negedge clk);
    checkOutput("masked_ph0_op", 32'(op), 32'd2);
    done[5] = 1'b0;
    @(negedge clk);
    checkOutput("masked_ph1_op", 32'(op), 32'd3);
    @(negedge clk);
    checkOutput("masked_fin_pulse", 32'(finished), 32'd1);
    done[5] = 1'b1;
    router_en[5] = 1'b1;
    @(negedge clk);

    // halt raised during LOAD of cycle 0 ends the run after that cycle's PHASE1.
    applyStimulus(16'd10);
    halt = 1'b1;
    @(negedge clk);
    checkOutput("halt_ph0_op", 32'(op), 32'd2);
    @(negedge clk);
    checkOutput("halt_ph1_op", 32'(op), 32'd3);
    @(negedge clk);
    halt = 1'b0;
    checkOutput("halt_fin_pulse", 32'(finished), 32'd1);
    checkOutput("halt_in_cycle", 32'(in_cycle), 32'd1);
    checkOutput("halt_fin_op", 32'(op), 32'd0);
    @(negedge clk);
    checkOutput("halt_idle_busy", 32'(busy), 32'd0);
    checkOutput("halt_idle_finished", 32'(finished), 32'd0);

    // Zero-length run: straight to FIN, no op issued.
    applyStimulus(16'd0);
    checkOutput("zero_fin_pulse", 32'(finished), 32'd1);
    checkOutput("zero_op", 32'(op), 32'd0);
    checkOutput("zero_in_cycle", 32'(in_cycle), 32'd0);
    @(negedge clk);
    checkOutput("zero_pulse_end", 32'(finished), 32'd0);
    checkOutput("zero_idle_op", 32'(op), 32'd0);

    // A second start mid-run is ignored.
    applyStimulus(16'd2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_ph1_op", 32'(op), 32'd3);
    @(negedge clk);
    checkOutput("restart_load_op", 32'(op), 32'd1);
    checkOutput("restart_in_cycle", 32'(in_cycle), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("restart_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in PH0 of cycle 1.
    applyStimulus(16'd3);
    repeat (4) @(negedge clk);
    checkOutput("arst_pre_op", 32'(op), 32'd2);
    checkOutput("arst_pre_in_cycle", 32'(in_cycle), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_op", 32'(op), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_in_cycle", 32'(in_cycle), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_no_start_op", 32'(op), 32'd0);
    checkOutput("post_reset_no_start_busy", 32'(busy), 32'd0);

`ifdef SEQ_WATCHDOG_EN
    applyStimulus(16'd1);
    done = 16'h0000;
    wait_cnt = 0;
    while (!error && wait_cnt < 2000) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("wd_trip_clks", 32'(wait_cnt), 32'd1024);
    checkOutput("wd_error", 32'(error), 32'd1);
    checkOutput("wd_busy", 32'(busy), 32'd0);
    checkOutput("wd_op", 32'(op), 32'd0);
    done = 16'hFFFF;
    repeat (2) @(negedge clk);
    checkOutput("wd_error_sticky", 32'(error), 32'd1);
    applyStimulus(16'd1);
    checkOutput("wd_error_cleared", 32'(error), 32'd0);
    checkOutput("wd_exit_idle_op", 32'(op), 32'd0);
`else
    applyStimulus(16'd1);
    done = 16'h0000;
    wait_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("nowd_error", 32'(error), 32'd0);
    checkOutput("nowd_still_load", 32'(op), 32'd1);
    checkOutput("nowd_busy", 32'(busy), 32'd1);
    done = 16'hFFFF;
    @(negedge clk);
    checkOutput("nowd_resume_op", 32'(op), 32'd2);
    repeat (3) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
